alu_mc: RTL

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_iter.sv | 81 ++++++++
 rtl/alu_mc.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states and flag bundle.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0011,
    OP_NOR   = 4'b0100,
    OP_XOR   = 4'b0101,
    OP_SLT   = 4'b0110,
    OP_SLL   = 4'b0111,
    OP_SRL   = 4'b1000,
    OP_SUBU  = 4'b1001,
    OP_SLTU  = 4'b1010,
    OP_ADDU  = 4'b1011,
    OP_MULTU = 4'b1100,
    OP_DIVU  = 4'b1101,
    OP_SRA   = 4'b1110,
    OP_RSVD  = 4'b1111
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Status flags other than zero, which is always derived from the result.
  typedef struct packed {
    logic overflow;
    logic lessthan;
    logic carry;
    logic div_by_zero;
  } flags_t;

endpackage

// File: rtl/alu_iter.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one bit per cycle.
// After load, WIDTH steps produce {hi,lo} = product, or lo = quotient, hi = remainder.
module alu_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             last
);

  logic [WIDTH-1:0] acc;    // partial product high half / running remainder
  logic [WIDTH-1:0] shreg;  // multiplier bits out, product/quotient bits in
  logic [WIDTH-1:0] opnd;   // multiplicand or divisor
  logic [SHW-1:0]   cnt;
  logic             div_q;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] sh_nxt;

  // Next accumulator/shift-register value for one multiply or divide step.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    acc_nxt = acc;
    sh_nxt  = shreg;
    add_sum = {1'b0, acc} + {1'b0, opnd};
    trial   = {acc, shreg[WIDTH-1]} - {1'b0, opnd};
    if (div_q) begin
      // trial[WIDTH] set means the shifted remainder is below the divisor: restore.
      if (!trial[WIDTH]) begin
        acc_nxt = trial[WIDTH-1:0];
        sh_nxt  = {shreg[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = {acc[WIDTH-2:0], shreg[WIDTH-1]};
        sh_nxt  = {shreg[WIDTH-2:0], 1'b0};
      end
    end else if (shreg[0]) begin
      acc_nxt = add_sum[WIDTH:1];
      sh_nxt  = {add_sum[0], shreg[WIDTH-1:1]};
    end else begin
      acc_nxt = {1'b0, acc[WIDTH-1:1]};
      sh_nxt  = {acc[0], shreg[WIDTH-1:1]};
    end
  end

  // Load operands on accept, then advance one bit per step and count iterations.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      acc   <= '0;
      shreg <= '0;
      opnd  <= '0;
      cnt   <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      acc   <= '0;
      shreg <= is_div ? a : b;
      opnd  <= is_div ? b : a;
      cnt   <= '0;
      div_q <= is_div;
    end else if (step) begin
      acc   <= acc_nxt;
      shreg <= sh_nxt;
      cnt   <= cnt + 1'b1;
    end
  end

  assign last = (cnt == SHW'(WIDTH - 1));
  assign lo   = shreg;
  assign hi   = acc;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative multu/divu,
// sequenced by an IDLE/RUN/DONE FSM with registered results and flags.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALU_OP,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [SHW-1:0]   shmt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             overflow,
  output logic             lessthan,
  output logic             carry,
  output logic             div_by_zero
);

  state_t           state;
  op_t              op_q;
  logic [WIDTH-1:0] rs_q, rt_q;
  logic [SHW-1:0]   shmt_q;
  logic             iter_q;

  logic             accept;
  logic             use_iter;
  logic [WIDTH-1:0] iter_lo, iter_hi;
  logic             iter_last;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] res, res_hi;
  flags_t           fl;

  // busy stays high through the done cycle, so IDLE with busy set is that cycle.
  assign accept   = (state == ST_IDLE) && !busy && start;
  // divu by zero takes the single-cycle path; multu always iterates.
  assign use_iter = (ALU_OP == OP_MULTU) || ((ALU_OP == OP_DIVU) && (rt != '0));

  alu_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
    .clk    (CLOCK_50),
    .reset  (reset),
    .load   (accept && use_iter),
    .step   (state == ST_RUN),
    .is_div (ALU_OP == OP_DIVU),
    .a      (rs),
    .b      (rt),
    .lo     (iter_lo),
    .hi     (iter_hi),
    .last   (iter_last)
  );

  // Single-cycle result, hi and flags from the latched operands.
  always_comb begin
    sum    = {1'b0, rs_q} + {1'b0, rt_q};
    diff   = {1'b0, rs_q} - {1'b0, rt_q};
    res    = '0;
    res_hi = '0;
    fl     = '0;
    case (op_q)
      OP_AND:  res = rs_q & rt_q;
      OP_OR:   res = rs_q | rt_q;
      OP_NOR:  res = ~(rs_q | rt_q);
      OP_XOR:  res = rs_q ^ rt_q;
      OP_ADD: begin
        res         = sum[WIDTH-1:0];
        fl.carry    = sum[WIDTH];
        fl.overflow = (rs_q[WIDTH-1] == rt_q[WIDTH-1]) && (res[WIDTH-1] != rs_q[WIDTH-1]);
      end
      OP_ADDU: begin
        res      = sum[WIDTH-1:0];
        fl.carry = sum[WIDTH];
      end
      OP_SUB: begin
        res         = diff[WIDTH-1:0];
        fl.carry    = diff[WIDTH];
        fl.overflow = (rs_q[WIDTH-1] != rt_q[WIDTH-1]) && (res[WIDTH-1] != rs_q[WIDTH-1]);
      end
      OP_SUBU: begin
        res      = diff[WIDTH-1:0];
        fl.carry = diff[WIDTH];
      end
      OP_SLT: begin
        res         = {{(WIDTH-1){1'b0}}, ($signed(rs_q) < $signed(rt_q))};
        fl.lessthan = res[0];
      end
      OP_SLTU: begin
        res         = {{(WIDTH-1){1'b0}}, (rs_q < rt_q)};
        fl.lessthan = res[0];
      end
      OP_SLL:  res = rt_q << shmt_q;
      OP_SRL:  res = rt_q >> shmt_q;
      OP_SRA:  res = $signed(rt_q) >>> shmt_q;
      OP_DIVU: begin
        res            = '1;
        res_hi         = rs_q;
        fl.div_by_zero = 1'b1;
      end
      default: res = '0;
    endcase
  end

  // Control FSM: accept, iterate, then register results with a one-cycle done pulse.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      alu_result  <= '0;
      hi          <= '0;
      zero        <= 1'b0;
      overflow    <= 1'b0;
      lessthan    <= 1'b0;
      carry       <= 1'b0;
      div_by_zero <= 1'b0;
      op_q        <= OP_AND;
      rs_q        <= '0;
      rt_q        <= '0;
      shmt_q      <= '0;
      iter_q      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            busy   <= 1'b1;
            op_q   <= op_t'(ALU_OP);
            rs_q   <= rs;
            rt_q   <= rt;
            shmt_q <= shmt;
            iter_q <= use_iter;
            state  <= use_iter ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          if (iter_last) state <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b1;
          if (iter_q) begin
            alu_result  <= iter_lo;
            hi          <= iter_hi;
            zero        <= (iter_lo == '0);
            overflow    <= 1'b0;
            lessthan    <= 1'b0;
            carry       <= 1'b0;
            div_by_zero <= 1'b0;
          end else begin
            alu_result  <= res;
            hi          <= res_hi;
            zero        <= (res == '0);
            overflow    <= fl.overflow;
            lessthan    <= fl.lessthan;
            carry       <= fl.carry;
            div_by_zero <= fl.div_by_zero;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
